// File: rtl/agc_tune_ctrl.sv
// agc_tune_ctrl: NCO retune sequencer with optional automatic IF gain control.
// A change of the SPI phase increment reloads the NCO, mutes audio and holds
// off for SETTLE_CYCLES clocks. After that the block is locked.
// Define AGC_TUNE_CTRL_AGC_EN to build the AGC. The AGC averages env_in over
// windows of 2^WIN_LOG2 samples and steps the gain between 0 and 3.
// Without the macro, gain_out is simply gain_spi delayed by one clock.
module agc_tune_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned WIN_LOG2      = 8,
  parameter logic [7:0]  HI_THRESH     = 8'd192,
  parameter logic [7:0]  LO_THRESH     = 8'd32
) (
  input  logic        clk,
  input  logic        RSTb,
  input  logic [15:0] phase_inc_spi,
  input  logic [1:0]  gain_spi,
  input  logic [7:0]  env_in,
  output logic [15:0] phase_inc_out,
  output logic [1:0]  gain_out,
  output logic        mute,
  output logic        locked
);

  // Last settle count value: the SETTLE state occupies exactly SETTLE_CYCLES clocks.
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 32'd1);

`ifdef AGC_TUNE_CTRL_AGC_EN
  localparam int unsigned AW = 8 + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] WIN_ONE = WIN_LOG2'(1'b1);
  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ADJUST  = 2'd2
  } state_t;
  localparam state_t ST_LOCKED = ST_MEASURE;
`else
  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;
  localparam state_t ST_LOCKED = ST_RUN;
`endif

  state_t      state_q, state_d;
  logic [15:0] phase_inc_q, phase_inc_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]  gain_q, gain_d;
  logic        mute_q, mute_d;
  logic        locked_q, locked_d;
  logic        retune_s;
  logic        settle_done_s;

`ifdef AGC_TUNE_CTRL_AGC_EN
  logic [1:0]          gain_spi_q, gain_spi_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic                gain_chg_s;
  logic [7:0]          avg_s;
  logic [AW-1:0]       env_ext_s;

  assign gain_chg_s = (gain_spi != gain_spi_q);
  // The window holds exactly 2^WIN_LOG2 samples, so the top 8 bits are the mean.
  assign avg_s      = acc_q[AW-1:WIN_LOG2];
  assign env_ext_s  = {{WIN_LOG2{1'b0}}, env_in};
`else
  logic unused_s;
  assign unused_s = ^{env_in, HI_THRESH, LO_THRESH, (WIN_LOG2 == 32'd0)};
`endif

  assign retune_s      = (phase_inc_spi != phase_inc_q);
  assign settle_done_s = (settle_cnt_q == SETTLE_LAST);

  // Next-state logic; priority is retune, then SPI gain change, then normal progression.
  always_comb begin
    state_d      = state_q;
    phase_inc_d  = phase_inc_q;
    settle_cnt_d = settle_cnt_q;
    gain_d       = gain_q;
`ifdef AGC_TUNE_CTRL_AGC_EN
    gain_spi_d   = gain_spi_q;
    acc_d        = acc_q;
    win_cnt_d    = win_cnt_q;
`else
    gain_d       = gain_spi;
`endif
    if (retune_s) begin
      phase_inc_d  = phase_inc_spi;
      state_d      = ST_SETTLE;
      settle_cnt_d = 16'd0;
`ifdef AGC_TUNE_CTRL_AGC_EN
      // The SPI gain change is consumed but not applied; the gain stays put.
      gain_spi_d   = gain_spi;
      acc_d        = {AW{1'b0}};
      win_cnt_d    = {WIN_LOG2{1'b0}};
`endif
    end
`ifdef AGC_TUNE_CTRL_AGC_EN
    else if (gain_chg_s) begin
      gain_spi_d = gain_spi;
      gain_d     = gain_spi;
      if (state_q == ST_SETTLE) begin
        // A gain write must not disturb the settle hold-off.
        if (settle_done_s) begin
          state_d      = ST_MEASURE;
          settle_cnt_d = 16'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end else begin
        state_d   = ST_MEASURE;
        acc_d     = {AW{1'b0}};
        win_cnt_d = {WIN_LOG2{1'b0}};
      end
    end
`endif
    else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_done_s) begin
            state_d      = ST_LOCKED;
            settle_cnt_d = 16'd0;
          end else begin
            settle_cnt_d = settle_cnt_q + 16'd1;
          end
        end
`ifdef AGC_TUNE_CTRL_AGC_EN
        ST_MEASURE: begin
          acc_d     = acc_q + env_ext_s;
          win_cnt_d = win_cnt_q + WIN_ONE;
          if (&win_cnt_q) begin
            state_d = ST_ADJUST;
          end else begin
            state_d = ST_MEASURE;
          end
        end
        ST_ADJUST: begin
          if ((avg_s > HI_THRESH) && (gain_q > 2'd0)) begin
            gain_d = gain_q - 2'd1;
          end else if ((avg_s < LO_THRESH) && (gain_q < 2'd3)) begin
            gain_d = gain_q + 2'd1;
          end else begin
            gain_d = gain_q;
          end
          acc_d     = {AW{1'b0}};
          win_cnt_d = {WIN_LOG2{1'b0}};
          state_d   = ST_MEASURE;
        end
`else
        ST_RUN: begin
          state_d = ST_RUN;
        end
`endif
        default: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = 16'd0;
        end
      endcase
    end
    // Status outputs follow the state being entered, so they are valid with it.
    if (state_d == ST_SETTLE) begin
      mute_d   = 1'b1;
      locked_d = 1'b0;
    end else begin
      mute_d   = 1'b0;
      locked_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RSTb) begin
      state_q      <= ST_SETTLE;
      phase_inc_q  <= 16'h0000;
      settle_cnt_q <= 16'd0;
      gain_q       <= 2'b00;
      mute_q       <= 1'b1;
      locked_q     <= 1'b0;
`ifdef AGC_TUNE_CTRL_AGC_EN
      gain_spi_q   <= 2'b00;
      acc_q        <= {AW{1'b0}};
      win_cnt_q    <= {WIN_LOG2{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      phase_inc_q  <= phase_inc_d;
      settle_cnt_q <= settle_cnt_d;
      gain_q       <= gain_d;
      mute_q       <= mute_d;
      locked_q     <= locked_d;
`ifdef AGC_TUNE_CTRL_AGC_EN
      gain_spi_q   <= gain_spi_d;
      acc_q        <= acc_d;
      win_cnt_q    <= win_cnt_d;
`endif
    end
  end

  assign phase_inc_out = phase_inc_q;
  assign gain_out      = gain_q;
  assign mute          = mute_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_agc_tune_ctrl.sv
// Directed bench for agc_tune_ctrl (SETTLE_CYCLES=16, WIN_LOG2=4, HI=192, LO=32).
// Per-cycle expectations go into a scoreboard queue and are checked after each edge.
module tb_agc_tune_ctrl;

  logic        clk = 1'b0;
  logic        RSTb;
  logic [15:0] phase_inc_spi;
  logic [1:0]  gain_spi;
  logic [7:0]  env_in;
  logic [15:0] phase_inc_out;
  logic [1:0]  gain_out;
  logic        mute;
  logic        locked;

  agc_tune_ctrl #(
    .SETTLE_CYCLES(16),
    .WIN_LOG2(4),
    .HI_THRESH(8'd192),
    .LO_THRESH(8'd32)
  ) dut (
    .clk(clk),
    .RSTb(RSTb),
    .phase_inc_spi(phase_inc_spi),
    .gain_spi(gain_spi),
    .env_in(env_in),
    .phase_inc_out(phase_inc_out),
    .gain_out(gain_out),
    .mute(mute),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ph;
    logic [1:0]  g;
    logic        m;
    logic        l;
  } exp_t;

  exp_t        sb_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_ph;
  logic [1:0]  exp_g;

  task automatic chk(input string tag, input string what, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s %s observed=%h expected=%h", tag, what, got, want);
    end
  endtask

  // Push the expectation for the coming edge, clock, then pop and compare.
  task automatic cyc(input string tag, input logic m, input logic l);
    exp_t  e;
    string t;
    e.ph = exp_ph;
    e.g  = exp_g;
    e.m  = m;
    e.l  = l;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "phase_inc_out", phase_inc_out, e.ph);
    chk(t, "gain_out", {14'd0, gain_out}, {14'd0, e.g});
    chk(t, "mute", {15'd0, mute}, {15'd0, e.m});
    chk(t, "locked", {15'd0, locked}, {15'd0, e.l});
  endtask

  // Called right after the edge that entered SETTLE: 15 more muted cycles, then lock.
  task automatic settle_after(input string tag);
    for (int i = 0; i < 15; i++) cyc(tag, 1'b1, 1'b0);
    cyc({tag, "_lock"}, 1'b0, 1'b1);
  endtask

  // Called right after a window start: 16 samples hold gain, the ADJUST edge applies g_after.
  task automatic win(input string tag, input logic [7:0] env, input logic [1:0] g_after);
    env_in = env;
    for (int i = 0; i < 16; i++) cyc(tag, 1'b0, 1'b1);
    exp_g = g_after;
    cyc({tag, "_adj"}, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    RSTb          = 1'b0;
    phase_inc_spi = 16'h0000;
    gain_spi      = 2'd0;
    env_in        = 8'd100;
    exp_ph        = 16'h0000;
    exp_g         = 2'd0;

    // Reset values
    repeat (3) cyc("reset", 1'b1, 1'b0);
    RSTb = 1'b1;
    settle_after("boot");
    repeat (3) cyc("boot_locked", 1'b0, 1'b1);

    // Retune while locked
    phase_inc_spi = 16'h1234;
    exp_ph        = 16'h1234;
    cyc("retune", 1'b1, 1'b0);
    settle_after("retune_settle");
    cyc("retune_locked", 1'b0, 1'b1);

    // Retune during SETTLE restarts the full count
    phase_inc_spi = 16'hABCD;
    exp_ph        = 16'hABCD;
    cyc("rt2", 1'b1, 1'b0);
    repeat (5) cyc("rt2_settle", 1'b1, 1'b0);
    phase_inc_spi = 16'h0F0F;
    exp_ph        = 16'h0F0F;
    cyc("rt3", 1'b1, 1'b0);
    settle_after("rt3_settle");

`ifdef AGC_TUNE_CTRL_AGC_EN
    // SPI gain load restarts the window
    gain_spi = 2'd3;
    env_in   = 8'd250;
    exp_g    = 2'd3;
    cyc("gain_load", 1'b0, 1'b1);
    win("hi", 8'd250, 2'd2);
    win("hi", 8'd250, 2'd1);
    win("hi", 8'd250, 2'd0);
    win("hi_sat", 8'd250, 2'd0);
    win("lo", 8'd10, 2'd1);
    win("lo", 8'd10, 2'd2);
    win("lo", 8'd10, 2'd3);
    win("lo_sat", 8'd10, 2'd3);
    win("mid", 8'd100, 2'd3);
    win("eq_hi", 8'd192, 2'd3);
    win("gt_hi", 8'd193, 2'd2);
    win("eq_lo", 8'd32, 2'd2);
    win("lt_lo", 8'd31, 2'd3);

    // Retune on MEASURE cycle 5 together with a gain write
    env_in = 8'd255;
    repeat (4) cyc("pre_rt", 1'b0, 1'b1);
    phase_inc_spi = 16'h5555;
    gain_spi      = 2'd1;
    exp_ph        = 16'h5555;
    cyc("rt_gain", 1'b1, 1'b0);
    env_in = 8'd180;
    settle_after("rt_gain_settle");
    // Average 180 holds only if the stale 255 samples were discarded
    win("post_rt", 8'd180, 2'd3);

    env_in = 8'd250;
    repeat (8) cyc("pre_rst", 1'b0, 1'b1);
`else
    // Gain follows gain_spi one clock later regardless of env_in
    gain_spi = 2'd2;
    env_in   = 8'd7;
    exp_g    = 2'd2;
    cyc("gain_follow", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      env_in = 8'($urandom_range(0, 255));
      cyc("gain_env", 1'b0, 1'b1);
    end
    phase_inc_spi = 16'h5555;
    gain_spi      = 2'd3;
    exp_ph        = 16'h5555;
    exp_g         = 2'd3;
    cyc("rt_gain", 1'b1, 1'b0);
    settle_after("rt_gain_settle");
    gain_spi = 2'd1;
    exp_g    = 2'd1;
    cyc("gain_follow2", 1'b0, 1'b1);
    env_in = 8'd0;
    repeat (3) cyc("gain_env0", 1'b0, 1'b1);
`endif

    // Reset mid-operation
    RSTb     = 1'b0;
    gain_spi = 2'd0;
    exp_ph   = 16'h0000;
    exp_g    = 2'd0;
    cyc("midrst", 1'b1, 1'b0);
    cyc("midrst", 1'b1, 1'b0);
    RSTb   = 1'b1;
    exp_ph = 16'h5555;
    cyc("post_rst", 1'b1, 1'b0);
    settle_after("post_rst_settle");
    repeat (2) cyc("post_rst_locked", 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
